// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Function : Pipeline sequencer for the 5-stage MIPS core. Detects load-use
//             and branch-operand hazards, redirects fetch for branches/J/JR
//             resolved in ID, freezes the pipe while data memory is busy
//             (with a watchdog), and counts stall/flush cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       RsAddr_id,
   input  logic [4:0]       RtAddr_id,
   input  logic             UseRs_id,
   input  logic             UseRt_id,
   input  logic             Branch_id,
   input  logic             Z,
   input  logic             J,
   input  logic             JR,
   input  logic             MemRead_ex,
   input  logic             RegWrite_ex,
   input  logic [4:0]       RegWriteAddr_ex,
   input  logic             MemRead_mem,
   input  logic [4:0]       RegWriteAddr_mem,
   input  logic             MemAccess_mem,
   input  logic             DMemReady,
   output logic             PC_IFWrite,
   output logic             IF_IDWrite,
   output logic             IF_Flush,
   output logic             ID_EXBubble,
   output logic             EX_MEMWrite,
   output logic [1:0]       PCSrc,
   output logic             MemTimeout,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   localparam logic [1:0]       c_RUN      = 2'd0;
   localparam logic [1:0]       c_MEMW     = 2'd1;
   localparam logic [1:0]       c_ERR      = 2'd2;
   localparam logic [7:0]       c_MAX_WAIT = 8'(MAX_WAIT);
   localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [7:0]       r_waitCnt;
   logic             r_memTimeout;
   logic [CNT_W-1:0] r_stallCnt;
   logic [CNT_W-1:0] r_flushCnt;

   logic       w_rsHitEx;
   logic       w_rtHitEx;
   logic       w_rsHitMem;
   logic       w_rtHitMem;
   logic       w_loadUse;
   logic       w_branchHaz;
   logic       w_stall;
   logic       w_memBusy;
   logic       w_runRules;
   logic [1:0] w_redirect;
   logic [7:0] w_waitNext;

   // Operand matches; register 0 is hardwired so it never creates a dependency
   assign w_rsHitEx  = UseRs_id && (RsAddr_id != 5'd0) && (RsAddr_id == RegWriteAddr_ex);
   assign w_rtHitEx  = UseRt_id && (RtAddr_id != 5'd0) && (RtAddr_id == RegWriteAddr_ex);
   assign w_rsHitMem = UseRs_id && (RsAddr_id != 5'd0) && (RsAddr_id == RegWriteAddr_mem);
   assign w_rtHitMem = UseRt_id && (RtAddr_id != 5'd0) && (RtAddr_id == RegWriteAddr_mem);

   // Load-use: loaded value is not available to ID until it leaves MEM
   assign w_loadUse   = MemRead_ex && (w_rsHitEx || w_rtHitEx);
   // Branch operands are compared in ID, so any in-flight producer stalls it
   assign w_branchHaz = (Branch_id || JR) &&
                        ((RegWrite_ex && (w_rsHitEx || w_rtHitEx)) ||
                         (MemRead_mem && (w_rsHitMem || w_rtHitMem)));
   assign w_stall     = w_loadUse || w_branchHaz;

   assign w_memBusy  = MemAccess_mem && !DMemReady;
   // Normal sequencing applies in RUN without a pending access, and on the
   // cycle a memory wait completes
   assign w_runRules = ((r_state == c_RUN) && !w_memBusy) ||
                       ((r_state == c_MEMW) && DMemReady);

   // Redirect source, fixed priority JR > J > taken branch
   assign w_redirect = JR              ? 2'b11 :
                       J               ? 2'b10 :
                       (Branch_id && Z) ? 2'b01 : 2'b00;

   assign w_waitNext = r_waitCnt + 8'd1;

   // Pipeline enables, bubble/flush and PC select
   always_comb begin
      PC_IFWrite  = 1'b0;
      IF_IDWrite  = 1'b0;
      IF_Flush    = 1'b0;
      ID_EXBubble = 1'b0;
      EX_MEMWrite = 1'b0;
      PCSrc       = 2'b00;
      if (!rst_n) begin
         IF_Flush    = 1'b1;
         ID_EXBubble = 1'b1;
      end else if (w_runRules) begin
         EX_MEMWrite = 1'b1;
         if (w_stall) begin
            ID_EXBubble = 1'b1;
         end else begin
            PC_IFWrite = 1'b1;
            IF_IDWrite = 1'b1;
            PCSrc      = w_redirect;
            IF_Flush   = (w_redirect != 2'b00);
         end
      end
   end

   // Memory-wait sequencer with watchdog; ERR is left only through reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= c_RUN;
         r_waitCnt    <= 8'd0;
         r_memTimeout <= 1'b0;
      end else begin
         case (r_state)
            c_RUN: begin
               if (w_memBusy) begin
                  r_waitCnt <= 8'd1;
                  if (c_MAX_WAIT <= 8'd1) begin
                     r_state      <= c_ERR;
                     r_memTimeout <= 1'b1;
                  end else begin
                     r_state <= c_MEMW;
                  end
               end
            end
            c_MEMW: begin
               if (DMemReady) begin
                  r_state   <= c_RUN;
                  r_waitCnt <= 8'd0;
               end else if (w_waitNext >= c_MAX_WAIT) begin
                  r_waitCnt    <= w_waitNext;
                  r_state      <= c_ERR;
                  r_memTimeout <= 1'b1;
               end else begin
                  r_waitCnt <= w_waitNext;
               end
            end
            c_ERR: begin
               r_state <= c_ERR;
            end
            default: begin
               r_state <= c_RUN;
            end
         endcase
      end
   end

   // Saturating stall and flush performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stallCnt <= '0;
         r_flushCnt <= '0;
      end else begin
         if (w_runRules && w_stall && (r_stallCnt != c_CNT_MAX)) begin
            r_stallCnt <= r_stallCnt + c_CNT_ONE;
         end
         if (IF_Flush && (r_flushCnt != c_CNT_MAX)) begin
            r_flushCnt <= r_flushCnt + c_CNT_ONE;
         end
      end
   end

   assign MemTimeout = r_memTimeout;
   assign StallCnt   = r_stallCnt;
   assign FlushCnt   = r_flushCnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Function : Self-checking bench for pipe_hazard_ctrl: vector table, directed
//             multi-cycle sequences and randomized stimulus against a
//             behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   localparam int CNT_W    = 8;
   localparam int MAX_WAIT = 4;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [4:0]       RsAddr_id, RtAddr_id, RegWriteAddr_ex, RegWriteAddr_mem;
   logic             UseRs_id, UseRt_id, Branch_id, Z, J, JR;
   logic             MemRead_ex, RegWrite_ex, MemRead_mem, MemAccess_mem, DMemReady;
   logic             PC_IFWrite, IF_IDWrite, IF_Flush, ID_EXBubble, EX_MEMWrite;
   logic [1:0]       PCSrc;
   logic             MemTimeout;
   logic [CNT_W-1:0] StallCnt, FlushCnt;

   pipe_hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .RsAddr_id(RsAddr_id), .RtAddr_id(RtAddr_id),
      .UseRs_id(UseRs_id), .UseRt_id(UseRt_id),
      .Branch_id(Branch_id), .Z(Z), .J(J), .JR(JR),
      .MemRead_ex(MemRead_ex), .RegWrite_ex(RegWrite_ex), .RegWriteAddr_ex(RegWriteAddr_ex),
      .MemRead_mem(MemRead_mem), .RegWriteAddr_mem(RegWriteAddr_mem),
      .MemAccess_mem(MemAccess_mem), .DMemReady(DMemReady),
      .PC_IFWrite(PC_IFWrite), .IF_IDWrite(IF_IDWrite), .IF_Flush(IF_Flush),
      .ID_EXBubble(ID_EXBubble), .EX_MEMWrite(EX_MEMWrite), .PCSrc(PCSrc),
      .MemTimeout(MemTimeout), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   always #5 clk = ~clk;

   int    nChecks = 0;
   int    nErrors = 0;
   string phase   = "init";

   // Reference model: consecutive low-ready cycles, error flag, event counts
   bit mErr;
   int mLow;
   int mStall;
   int mFlush;
   // Expected outputs for the current cycle
   int eP, eI, eF, eB, eE, eS;
   bit expRun, expStall;

   typedef struct {
      int rs, rt, useRs, useRt, br, z, j, jr;
      int memRdEx, regWrEx, dstEx, memRdMem, dstMem;
      int pcw, ifid, flush, bubble, exmem, pcsrc;
   } vec_t;
   vec_t tbl[16];

   function automatic void chk(string name, int act, int exp);
      nChecks++;
      if (act != exp) begin
         nErrors++;
         $display("FAIL %s/%s: got %0d expected %0d", phase, name, act, exp);
      end
   endfunction

   function automatic bit hit(logic [4:0] a, logic [4:0] d, logic u);
      return u && (a != 5'd0) && (a == d);
   endfunction

   task automatic clear_inputs();
      RsAddr_id = 0; RtAddr_id = 0; UseRs_id = 0; UseRt_id = 0;
      Branch_id = 0; Z = 0; J = 0; JR = 0;
      MemRead_ex = 0; RegWrite_ex = 0; RegWriteAddr_ex = 0;
      MemRead_mem = 0; RegWriteAddr_mem = 0;
      MemAccess_mem = 0; DMemReady = 1;
   endtask

   // Expected behaviour derived from the hazard/redirect/freeze rules
   task automatic compute_expect();
      bit opsEx, opsMem;
      opsEx  = hit(RsAddr_id, RegWriteAddr_ex, UseRs_id)  || hit(RtAddr_id, RegWriteAddr_ex, UseRt_id);
      opsMem = hit(RsAddr_id, RegWriteAddr_mem, UseRs_id) || hit(RtAddr_id, RegWriteAddr_mem, UseRt_id);
      expStall = (MemRead_ex && opsEx) ||
                 ((Branch_id || JR) && ((RegWrite_ex && opsEx) || (MemRead_mem && opsMem)));
      eP = 0; eI = 0; eF = 0; eB = 0; eE = 0; eS = 0; expRun = 0;
      if (!rst_n) begin
         mErr = 0; mLow = 0; mStall = 0; mFlush = 0;
         eF = 1; eB = 1;
      end else begin
         expRun = !mErr && ((mLow == 0) ? !(MemAccess_mem && !DMemReady) : DMemReady);
         if (expRun) begin
            eE = 1;
            if (expStall) eB = 1;
            else begin
               eP = 1; eI = 1;
               eS = JR ? 3 : J ? 2 : (Branch_id && Z) ? 1 : 0;
               eF = (eS != 0);
            end
         end
      end
   endtask

   // One clock: compare at the falling edge, advance the model at the rising edge
   task automatic cycle();
      @(negedge clk);
      compute_expect();
      chk("PC_IFWrite",  PC_IFWrite,  eP);
      chk("IF_IDWrite",  IF_IDWrite,  eI);
      chk("IF_Flush",    IF_Flush,    eF);
      chk("ID_EXBubble", ID_EXBubble, eB);
      chk("EX_MEMWrite", EX_MEMWrite, eE);
      chk("PCSrc",       PCSrc,       eS);
      chk("MemTimeout",  MemTimeout,  mErr);
      chk("StallCnt",    StallCnt,    mStall);
      chk("FlushCnt",    FlushCnt,    mFlush);
      @(posedge clk);
      if (rst_n) begin
         if (expRun && expStall) mStall = (mStall < CNT_MAX) ? mStall + 1 : CNT_MAX;
         if (eF != 0)            mFlush = (mFlush < CNT_MAX) ? mFlush + 1 : CNT_MAX;
         if (!mErr) begin
            if (mLow == 0) begin
               if (MemAccess_mem && !DMemReady) mLow = 1;
            end else if (DMemReady) mLow = 0;
            else mLow++;
            if (mLow >= MAX_WAIT) mErr = 1;
         end
      end
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 0;
      clear_inputs();
      cycle();
      rst_n = 1;
   endtask

   task automatic apply_vec(vec_t v);
      RsAddr_id = 5'(v.rs); RtAddr_id = 5'(v.rt);
      UseRs_id = 1'(v.useRs); UseRt_id = 1'(v.useRt);
      Branch_id = 1'(v.br); Z = 1'(v.z); J = 1'(v.j); JR = 1'(v.jr);
      MemRead_ex = 1'(v.memRdEx); RegWrite_ex = 1'(v.regWrEx); RegWriteAddr_ex = 5'(v.dstEx);
      MemRead_mem = 1'(v.memRdMem); RegWriteAddr_mem = 5'(v.dstMem);
      MemAccess_mem = 0; DMemReady = 1;
   endtask

   initial begin
      //           rs rt uRs uRt br z j jr mrEx rwEx dEx mrMem dMem | pcw ifid fl bub exm src
      tbl[0]  = '{1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0};
      tbl[1]  = '{2, 7, 1, 1, 0, 0, 0, 0, 1, 1, 2, 0, 0,  0, 0, 0, 1, 1, 0};
      tbl[2]  = '{1, 5, 1, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0,  0, 0, 0, 1, 1, 0};
      tbl[3]  = '{1, 5, 1, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0,  1, 1, 0, 0, 1, 0};
      tbl[4]  = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 1, 0};
      tbl[5]  = '{6, 1, 1, 1, 0, 0, 0, 0, 0, 1, 6, 0, 0,  1, 1, 0, 0, 1, 0};
      tbl[6]  = '{1, 2, 1, 1, 1, 1, 0, 0, 0, 1, 9, 1, 8,  1, 1, 1, 0, 1, 1};
      tbl[7]  = '{1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0};
      tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 1, 1, 0, 1, 2};
      tbl[9]  = '{3, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0, 1, 3};
      tbl[10] = '{3, 4, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0,  1, 1, 1, 0, 1, 3};
      tbl[11] = '{3, 4, 1, 1, 1, 1, 0, 0, 0, 1, 4, 0, 0,  0, 0, 0, 1, 1, 0};
      tbl[12] = '{9, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 9,  0, 0, 0, 1, 1, 0};
      tbl[13] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0,  1, 1, 1, 0, 1, 1};
      tbl[14] = '{1, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 6,  0, 0, 0, 1, 1, 0};
      tbl[15] = '{5, 0, 1, 0, 0, 0, 1, 0, 0, 1, 5, 0, 0,  1, 1, 1, 0, 1, 2};

      rst_n = 0;
      clear_inputs();

      // Reset state
      phase = "reset";
      #1;
      chk("rst PC_IFWrite", PC_IFWrite, 0);
      chk("rst IF_Flush", IF_Flush, 1);
      chk("rst ID_EXBubble", ID_EXBubble, 1);
      chk("rst EX_MEMWrite", EX_MEMWrite, 0);
      reset_dut();

      // Single-cycle vector table
      phase = "table";
      for (int i = 0; i < 16; i++) begin
         apply_vec(tbl[i]);
         #1;
         chk($sformatf("t%0d PC_IFWrite", i),  PC_IFWrite,  tbl[i].pcw);
         chk($sformatf("t%0d IF_IDWrite", i),  IF_IDWrite,  tbl[i].ifid);
         chk($sformatf("t%0d IF_Flush", i),    IF_Flush,    tbl[i].flush);
         chk($sformatf("t%0d ID_EXBubble", i), ID_EXBubble, tbl[i].bubble);
         chk($sformatf("t%0d EX_MEMWrite", i), EX_MEMWrite, tbl[i].exmem);
         chk($sformatf("t%0d PCSrc", i),       PCSrc,       tbl[i].pcsrc);
         cycle();
      end

      // lw $2 then dependent add: one stall
      phase = "loaduse";
      reset_dut();
      MemRead_ex = 1; RegWrite_ex = 1; RegWriteAddr_ex = 2; RsAddr_id = 2; UseRs_id = 1;
      #1;
      chk("lu PC_IFWrite", PC_IFWrite, 0);
      chk("lu ID_EXBubble", ID_EXBubble, 1);
      cycle();
      MemRead_ex = 0; RegWrite_ex = 0; MemRead_mem = 1; RegWriteAddr_mem = 2;
      cycle();
      chk("lu StallCnt", StallCnt, 1);

      // lw $3 then beq on $3: two stalls, then taken redirect
      phase = "lwbeq";
      reset_dut();
      MemRead_ex = 1; RegWrite_ex = 1; RegWriteAddr_ex = 3;
      Branch_id = 1; Z = 1; RsAddr_id = 3; UseRs_id = 1; RtAddr_id = 0; UseRt_id = 1;
      cycle();
      MemRead_ex = 0; RegWrite_ex = 0; MemRead_mem = 1; RegWriteAddr_mem = 3;
      #1;
      chk("lwbeq 2nd stall", PC_IFWrite, 0);
      cycle();
      MemRead_mem = 0;
      #1;
      chk("lwbeq PCSrc", PCSrc, 1);
      chk("lwbeq IF_Flush", IF_Flush, 1);
      cycle();
      clear_inputs();
      cycle();
      chk("lwbeq StallCnt", StallCnt, 2);
      chk("lwbeq FlushCnt", FlushCnt, 1);

      // ALU result into JR: one stall; register 0 never stalls
      phase = "jr";
      reset_dut();
      RegWrite_ex = 1; RegWriteAddr_ex = 4; JR = 1; RsAddr_id = 4; UseRs_id = 1;
      cycle();
      RegWrite_ex = 0;
      #1;
      chk("jr PCSrc", PCSrc, 3);
      chk("jr IF_Flush", IF_Flush, 1);
      cycle();
      RegWrite_ex = 1; RegWriteAddr_ex = 0; RsAddr_id = 0;
      #1;
      chk("jr r0 PC_IFWrite", PC_IFWrite, 1);
      cycle();
      chk("jr StallCnt", StallCnt, 1);

      // Memory wait of 3 cycles, then normal
      phase = "memwait";
      reset_dut();
      MemAccess_mem = 1; DMemReady = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("mw EX_MEMWrite", EX_MEMWrite, 0);
         chk("mw ID_EXBubble", ID_EXBubble, 0);
         cycle();
      end
      DMemReady = 1;
      #1;
      chk("mw resume EX_MEMWrite", EX_MEMWrite, 1);
      chk("mw resume PC_IFWrite", PC_IFWrite, 1);
      cycle();
      chk("mw MemTimeout", MemTimeout, 0);

      // Watchdog: timeout after MAX_WAIT low cycles, sticky until reset
      phase = "timeout";
      reset_dut();
      MemAccess_mem = 1; DMemReady = 0;
      for (int i = 0; i < MAX_WAIT - 1; i++) cycle();
      chk("to before limit", MemTimeout, 0);
      cycle();
      chk("to MemTimeout", MemTimeout, 1);
      DMemReady = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("to freeze PC_IFWrite", PC_IFWrite, 0);
         chk("to freeze EX_MEMWrite", EX_MEMWrite, 0);
         cycle();
      end
      #2;
      rst_n = 0;
      #1;
      chk("to async clear", MemTimeout, 0);
      chk("to async bubble", ID_EXBubble, 1);
      clear_inputs();
      cycle();
      rst_n = 1;

      // Reset while waiting on memory returns to normal sequencing
      phase = "rstmemw";
      MemAccess_mem = 1; DMemReady = 0;
      cycle();
      cycle();
      #2;
      rst_n = 0;
      cycle();
      rst_n = 1;
      clear_inputs();
      #1;
      chk("rm EX_MEMWrite", EX_MEMWrite, 1);
      chk("rm PC_IFWrite", PC_IFWrite, 1);
      cycle();

      // Counter saturation
      phase = "saturate";
      reset_dut();
      MemRead_ex = 1; RegWriteAddr_ex = 7; RsAddr_id = 7; UseRs_id = 1;
      repeat ((1 << CNT_W) + 5) cycle();
      chk("sat StallCnt", StallCnt, CNT_MAX);
      clear_inputs();
      J = 1;
      repeat ((1 << CNT_W) + 5) cycle();
      chk("sat FlushCnt", FlushCnt, CNT_MAX);

      // Randomized traffic against the reference model
      phase = "random";
      reset_dut();
      for (int n = 0; n < 600; n++) begin
         if (mErr) begin
            rst_n = 0;
            clear_inputs();
            cycle();
            rst_n = 1;
         end
         RsAddr_id = 5'($urandom_range(0, 7));
         RtAddr_id = 5'($urandom_range(0, 7));
         UseRs_id = 1'($urandom); UseRt_id = 1'($urandom);
         case ($urandom_range(0, 5))
            0: begin Branch_id = 1; J = 0; JR = 0; end
            1: begin Branch_id = 0; J = 1; JR = 0; end
            2: begin Branch_id = 0; J = 0; JR = 1; end
            3: begin Branch_id = 1'($urandom); J = 1'($urandom); JR = 1'($urandom); end
            default: begin Branch_id = 0; J = 0; JR = 0; end
         endcase
         Z = 1'($urandom);
         MemRead_ex = 1'($urandom); RegWrite_ex = 1'($urandom);
         RegWriteAddr_ex = 5'($urandom_range(0, 7));
         MemRead_mem = 1'($urandom); RegWriteAddr_mem = 5'($urandom_range(0, 7));
         MemAccess_mem = ($urandom_range(0, 3) == 0);
         DMemReady = (mLow > 0) ? ($urandom_range(0, 9) < 6) : 1'($urandom);
         // keep hazards away from frozen cycles and wait completions
         if ((MemAccess_mem && !DMemReady) || (mLow > 0)) begin
            MemRead_ex = 0; RegWrite_ex = 0; MemRead_mem = 0;
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
`default_nettype wire
